// File: rtl/seg_pkg.sv
// Shared segment-display constants and the hex-to-pattern helper used by seg_scan_driver.
package seg_pkg;

    localparam int SEG_W = 8;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    // Entry n is the {a,b,c,d,e,f,g} active-high pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] nibble,
                                                 input logic       dot,
                                                 input logic       blank);
        logic [6:0] segs;
        segs = blank ? 7'b0000000 : SEG_FONT[nibble];
        return ~{segs, dot};
    endfunction

endpackage

// File: rtl/seg_lzb_mask.sv
// Leading-zero mask: bit i set when digit i and every enabled digit above it are zero (digit 0 never set).
module seg_lzb_mask
    import seg_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   ena,
    output logic [DIGITS-1:0]   lz_mask
);

    always_comb begin
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        // Disabled digits never break the run of leading zeros.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run        = run & (~ena[i] | (value[4*i +: 4] == 4'h0));
            lz_mask[i] = run & (i != 0);
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multi-digit time-multiplexed hex 7-segment driver with double-buffered inputs.
// Optional per-digit blinking is enabled by defining SEG_SCAN_BLINK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SCAN_DIV    = 50000,
    parameter bit LZB_DEFAULT = 1'b1
`ifdef SEG_SCAN_BLINK_EN
    , parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     ena,
    input  logic [DIGITS-1:0]     dot,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]     blink,
`endif
    input  logic                  lzb,
    output logic                  busy,
    output logic [SEG_W-1:0]      seg,
    output logic [DIGITS-1:0]     an,
    output logic [SEG_W*DIGITS-1:0] seg_all,
    output logic                  frame
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]     pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [DIGITS-1:0]       pend_ena_q, pend_ena_d, act_ena_q, act_ena_d;
    logic [DIGITS-1:0]       pend_dot_q, pend_dot_d, act_dot_q, act_dot_d;
    logic                    busy_q, busy_d;
    logic                    lzb_q, lzb_d;
    logic                    frame_q, frame_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic [DIGITS-1:0]       an_q, an_d;
    logic [SEG_W*DIGITS-1:0] seg_all_q, seg_all_d;

    logic                    tc, wrap;
    logic [DIGITS-1:0]       lz_mask;
    logic [DIGITS-1:0][SEG_W-1:0] pats;

`ifdef SEG_SCAN_BLINK_EN
    localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

    logic [DIGITS-1:0] pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
    logic [BF_W-1:0]   bcnt_q, bcnt_d;
    logic              off_q, off_d;
`endif

    seg_lzb_mask #(
        .DIGITS (DIGITS)
    ) u_lzb_mask (
        .value   (act_val_q),
        .ena     (act_ena_q),
        .lz_mask (lz_mask)
    );

    always_comb begin
        tc      = (presc_q == PRESC_LAST);
        wrap    = tc && (idx_q == IDX_LAST);
        presc_d = tc ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        pend_val_d = load ? value : pend_val_q;
        pend_ena_d = load ? ena   : pend_ena_q;
        pend_dot_d = load ? dot   : pend_dot_q;
        // A load on the frame boundary still commits the older pending data.
        busy_d     = load | (busy_q & ~wrap);
        act_val_d  = (wrap && busy_q) ? pend_val_q : act_val_q;
        act_ena_d  = (wrap && busy_q) ? pend_ena_q : act_ena_q;
        act_dot_d  = (wrap && busy_q) ? pend_dot_q : act_dot_q;
        lzb_d      = wrap ? lzb : lzb_q;
        frame_d    = wrap;

`ifdef SEG_SCAN_BLINK_EN
        pend_blink_d = load ? blink : pend_blink_q;
        act_blink_d  = (wrap && busy_q) ? pend_blink_q : act_blink_q;
        bcnt_d       = bcnt_q;
        off_d        = off_q;
        if (wrap) begin
            bcnt_d = (bcnt_q == BF_LAST) ? '0 : bcnt_q + 1'b1;
            off_d  = (bcnt_q == BF_LAST) ? ~off_q : off_q;
        end
`endif

        for (int i = 0; i < DIGITS; i++) begin
            pats[i] = hex2seg(act_val_q[4*i +: 4], act_dot_q[i],
                              ~act_ena_q[i] | (lzb_q & lz_mask[i]));
`ifdef SEG_SCAN_BLINK_EN
            if (off_q && act_blink_q[i]) begin
                pats[i] = SEG_BLANK;
            end
`endif
        end

        // seg and an both derive from the same idx_q so they always switch together.
        seg_all_d = pats;
        seg_d     = pats[idx_q];
        an_d      = ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_ena_q <= '0;
            pend_dot_q <= '0;
            act_val_q  <= '0;
            act_ena_q  <= '0;
            act_dot_q  <= '0;
            busy_q     <= 1'b0;
            lzb_q      <= LZB_DEFAULT;
            frame_q    <= 1'b0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
            seg_all_q  <= '1;
`ifdef SEG_SCAN_BLINK_EN
            pend_blink_q <= '0;
            act_blink_q  <= '0;
            bcnt_q       <= '0;
            off_q        <= 1'b0;
`endif
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_ena_q <= pend_ena_d;
            pend_dot_q <= pend_dot_d;
            act_val_q  <= act_val_d;
            act_ena_q  <= act_ena_d;
            act_dot_q  <= act_dot_d;
            busy_q     <= busy_d;
            lzb_q      <= lzb_d;
            frame_q    <= frame_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            seg_all_q  <= seg_all_d;
`ifdef SEG_SCAN_BLINK_EN
            pend_blink_q <= pend_blink_d;
            act_blink_q  <= act_blink_d;
            bcnt_q       <= bcnt_d;
            off_q        <= off_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign seg     = seg_q;
    assign an      = an_q;
    assign seg_all = seg_all_q;
    assign frame   = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4) against a frame-level reference model.
`timescale 1ns/1ps
module tb_seg_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int FR = D * SD;
`ifdef SEG_SCAN_BLINK_EN
    localparam int BF = 2;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           load = 1'b0;
    logic           lzb = 1'b0;
    logic [4*D-1:0] value = '0;
    logic [D-1:0]   ena = '0;
    logic [D-1:0]   dot = '0;
`ifdef SEG_SCAN_BLINK_EN
    logic [D-1:0]   blink = '0;
`endif
    logic           busy, frame;
    logic [7:0]     seg;
    logic [D-1:0]   an;
    logic [8*D-1:0] seg_all;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycle count since reset, boundaries seen, and both buffers.
    int             m_cyc, m_nb;
    logic           m_busy, m_lzb;
    logic [4*D-1:0] m_pval, m_aval;
    logic [D-1:0]   m_pena, m_pdot, m_aena, m_adot, m_pblink, m_ablink;
    logic [7:0]     e_seg;
    logic [D-1:0]   e_an;
    logic [8*D-1:0] e_all;
    logic           e_busy, e_frame;

    logic [6:0] tb_font [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    typedef struct {
        logic [15:0] value;
        logic [3:0]  ena;
        logic [3:0]  dot;
        logic        lzb;
        logic [31:0] exp_all;
    } vec_t;
    vec_t vecs[$];

    logic [7:0] font_exp [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                  8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DIGITS      (D),
        .SCAN_DIV    (SD),
        .LZB_DEFAULT (1'b1)
`ifdef SEG_SCAN_BLINK_EN
        , .BLINK_FRAMES (BF)
`endif
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .value   (value),
        .ena     (ena),
        .dot     (dot),
`ifdef SEG_SCAN_BLINK_EN
        .blink   (blink),
`endif
        .lzb     (lzb),
        .busy    (busy),
        .seg     (seg),
        .an      (an),
        .seg_all (seg_all),
        .frame   (frame)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // A digit shows its glyph only if enabled and, with blanking on, it is digit 0
    // or sits at/below the highest enabled non-zero digit.
    function automatic logic [7:0] model_digit(input int i, input bit off);
        int         top;
        bit         shown;
        logic [6:0] segs;
        logic [7:0] p;
        top = -1;
        for (int j = 0; j < D; j++) begin
            if (m_aena[j] && (m_aval[4*j +: 4] != 4'h0)) top = j;
        end
        shown = m_aena[i] && (!m_lzb || i == 0 || i <= top);
        segs  = shown ? tb_font[m_aval[4*i +: 4]] : 7'b0;
        p     = ~{segs, m_adot[i]};
        if (off && m_ablink[i]) p = 8'hFF;
        return p;
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_nb = 0; m_busy = 1'b0; m_lzb = 1'b1;
        m_pval = '0; m_aval = '0; m_pena = '0; m_pdot = '0;
        m_aena = '0; m_adot = '0; m_pblink = '0; m_ablink = '0;
    endtask

    task automatic tick();
        int ib;
        bit bnd, off;
        ib  = (m_cyc / SD) % D;
        bnd = (m_cyc % FR) == FR - 1;
        off = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        off = ((m_nb / BF) % 2) == 1;
`endif
        for (int i = 0; i < D; i++) e_all[8*i +: 8] = model_digit(i, off);
        e_seg   = e_all[8*ib +: 8];
        e_an    = ~(D'(1) << ib);
        e_frame = bnd;
        if (bnd) begin
            if (m_busy) begin
                m_aval = m_pval; m_aena = m_pena; m_adot = m_pdot; m_ablink = m_pblink;
            end
            m_lzb = lzb;
            m_nb++;
        end
        if (load) begin
            m_pval = value; m_pena = ena; m_pdot = dot;
`ifdef SEG_SCAN_BLINK_EN
            m_pblink = blink;
`endif
        end
        m_busy = load | (m_busy & !bnd);
        e_busy = m_busy;
        m_cyc++;
        @(posedge clk);
        #1;
        check("seg", seg, e_seg);
        check("an", an, e_an);
        check("seg_all", seg_all, e_all);
        check("busy", busy, e_busy);
        check("frame", frame, e_frame);
    endtask

    task automatic wait_commit();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((m_cyc % FR != 0 || m_busy) && n < 4 * FR);
        check("commit_wait", n < 4 * FR, 1);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seg"}, seg, 8'hFF);
        check({tag, "_an"}, an, 4'hF);
        check({tag, "_seg_all"}, seg_all, 32'hFFFF_FFFF);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_frame"}, frame, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int n = 0; n < 16; n++) begin
            vecs.push_back('{{4{n[3:0]}}, 4'hF, 4'b0010, 1'b0,
                             {font_exp[n], font_exp[n], font_exp[n] & 8'hFE, font_exp[n]}});
        end
        vecs.push_back('{16'h0050, 4'hF, 4'b0000, 1'b1, 32'hFFFF_4903});
        vecs.push_back('{16'h0000, 4'hF, 4'b0000, 1'b1, 32'hFFFF_FF03});
        vecs.push_back('{16'h1050, 4'b0111, 4'b0100, 1'b1, 32'hFFFE_4903});
        vecs.push_back('{16'h0050, 4'hF, 4'b0000, 1'b0, 32'h0303_4903});
        vecs.push_back('{16'h1234, 4'b0101, 4'b0000, 1'b0, 32'hFF25_FF99});

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            tick();
            check("an_seq", an, an_tab[(k / SD) % D]);
            check("frame_seq", frame, (k % FR) == FR - 1);
        end

        foreach (vecs[v]) begin
            value = vecs[v].value; ena = vecs[v].ena; dot = vecs[v].dot; lzb = vecs[v].lzb;
            load = 1'b1;
            tick();
            load = 1'b0;
            check("vec_busy", busy, 1'b1);
            wait_commit();
            check("vec_seg_all", seg_all, vecs[v].exp_all);
            check("vec_busy_clr", busy, 1'b0);
        end

        // Load on the boundary edge, then overwrite within the next frame.
        lzb = 1'b0; ena = 4'hF; dot = 4'h0;
        while (m_cyc % FR != 2) tick();
        value = 16'h1234; load = 1'b1;
        tick();
        load = 1'b0;
        while (m_cyc % FR != FR - 1) tick();
        value = 16'h5678; load = 1'b1;
        tick();
        load = 1'b0;
        check("coll_busy", busy, 1'b1);
        tick();
        check("coll_first", seg_all, 32'h9F25_0D99);
        while (m_cyc % FR != 5) tick();
        value = 16'h9ABC; load = 1'b1;
        tick();
        load = 1'b0;
        check("coll_busy2", busy, 1'b1);
        while (m_cyc % FR != 0) tick();
        check("coll_busy_clr", busy, 1'b0);
        tick();
        check("coll_last", seg_all, 32'h0911_C163);

        // Asynchronous reset while digit 2 is being driven.
        do tick(); while ((((m_cyc - 1) / SD) % D) != 2);
        check("pre_reset_an", an, 4'hB);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            check("restart_an", an, an_tab[(k / SD) % D]);
        end

`ifdef SEG_SCAN_BLINK_EN
        value = 16'h1234; ena = 4'hF; dot = 4'h0; lzb = 1'b0; blink = 4'b0001;
        load = 1'b1;
        tick();
        load = 1'b0;
        blink = 4'b0000;
        wait_commit();
        for (int f = 0; f < 8; f++) begin
            while (m_cyc % FR != 8) tick();
            check("blink_d0", seg_all[7:0], ((m_nb / BF) % 2 == 1) ? 8'hFF : 8'h99);
            check("blink_d1", seg_all[15:8], 8'h0D);
            tick();
        end
`endif

        for (int k = 0; k < 2000; k++) begin
            load  = ($urandom_range(0, 39) == 0);
            value = (4*D)'($urandom);
            ena   = D'($urandom);
            dot   = D'($urandom);
            lzb   = 1'($urandom);
`ifdef SEG_SCAN_BLINK_EN
            blink = D'($urandom);
`endif
            tick();
        end
        load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
